instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch unit: the initiator side of the synchronous-read `instructionmemory`. It owns the program counter and drives `adress` into the memory. It accounts for the memory's one-cycle registered read latency and presents each fetched instruction with its PC and a valid flag to decode. It supports decode back-pressure (stall), zero-bubble control-flow redirect, a halt state, and a count of accepted instructions.

## Interface
Parameters:
- `ADDR_W`, 10, instruction-word address width; matches the memory's address port.
- `DATA_W`, 32, instruction width.
- `RESET_PC`, 0, first word address fetched after reset.
- `COUNT_W`, 16, width of `fetch_count`.

Ports:
- `Clk`  in  1  single clock, rising edge; the same clock as `instructionmemory`.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  decode cannot accept the presented instruction; hold it.
- `halt`  in  1  stop fetching; enter HALTED.
- `redirect_valid`  in  1  branch/jump taken; restart fetch at `redirect_addr`.
- `redirect_addr`  in  ADDR_W  word address of the redirect target.
- `imem_addr`  out  ADDR_W  address to the memory; combinational from state and inputs.
- `imem_data`  in  DATA_W  registered memory output; holds M[address sampled at the previous edge].
- `instr`  out  DATA_W  equals `imem_data` (pass-through).
- `instr_pc`  out  ADDR_W  word address of `instr` (register `rsp_pc`).
- `instr_valid`  out  1  `instr` is valid (register `rsp_valid`).
- `halted`  out  1  high while the unit is in HALTED.
- `fetch_count`  out  COUNT_W  number of accepted instructions, modulo 2^COUNT_W.

## Operation
- State registers: `pc` (next address to request), `rsp_pc`, `rsp_valid`, FSM state in {FILL, RUN, HALTED}, `fetch_count`.
- Reset values: `pc`=RESET_PC, `rsp_pc`=RESET_PC, `rsp_valid`=0, state=FILL, `fetch_count`=0, `halted`=0. During reset `imem_addr`=RESET_PC.
- Accept event: `instr_valid && !stall`. Each accept increments `fetch_count` by 1, wrapping at 2^COUNT_W.
- Per-cycle priority in every state: redirect > halt > stall > advance.
- Redirect:
  - `imem_addr`=`redirect_addr`.
  - Next cycle: `rsp_pc`=`redirect_addr`, `pc`=`redirect_addr`+1, `rsp_valid`=1, state=RUN.
  - The presented instruction is not re-presented. It counts as accepted only if it was valid and `stall`=0.
- Halt (FILL or RUN):
  - `imem_addr`=`rsp_pc`.
  - Next cycle: `rsp_valid`=0, state=HALTED; `pc` and `rsp_pc` are held.
- HALTED:
  - `imem_addr`=`rsp_pc`; `instr_valid`=0; `halted`=1; `stall` and `halt` are ignored.
  - The only exit is a redirect.
- Stall (RUN):
  - `imem_addr`=`rsp_pc`, so the memory re-reads the same word and `instr` stays stable.
  - All registers hold.
- Advance:
  - FILL is left after one cycle; it is also the first cycle out of reset.
  - `imem_addr`=`pc`.
  - Next cycle: `rsp_pc`=`pc`, `pc`=`pc`+1, `rsp_valid`=1, state=RUN.
  - In FILL, `stall` is ignored because nothing is valid yet.
- Arithmetic: `pc`+1 is modulo 2^ADDR_W, so 1023 → 0 with no flag. `redirect_addr` is used unmodified.

## Timing
- Fetch latency: the address is driven in cycle n and the instruction is visible with `instr_valid`=1 in cycle n+1.
- After reset release, the first edge samples RESET_PC. `instr_valid`=1 with `instr_pc`=RESET_PC from the cycle after the first edge.
- Sustained throughput is one instruction per cycle with no stall. Redirect costs zero bubbles.
- Stall takes effect combinationally on `imem_addr` in the same cycle. Outputs are unchanged in the next cycle.
- Asynchronous reset mid-operation: registers clear immediately. The next rising edge after deassertion behaves as the first FILL cycle.
- Simultaneous `redirect_valid` and `halt`: redirect wins and the unit stays out of HALTED.
- Simultaneous `redirect_valid` and `stall` with `instr_valid`=1: redirect wins; no accept is counted.

## Test plan
- Reset then free run against `instructionmemory` loaded with its default program.
  - Cycles 1..11 present `instr_pc`=0..10 with the matching words, for example PC 5 shows 0x1C2022A2.
  - `fetch_count`=11 after the 11th accept.
- Stall held for 3 cycles while PC 6 is presented → `instr_pc`=6 and `instr`=0x1C432AA2 stay stable, and `fetch_count` does not change.
  - Release → PC 7 appears next cycle.
- Redirect to 2 while PC 8 is presented, with `stall`=0 → the next cycle shows PC 2 (0x21E21032), then PC 3 follows; PC 8 is counted once.
- Halt at PC 4 → the next cycle has `instr_valid`=0 and `halted`=1. It stays halted for 5 cycles regardless of `stall`/`halt`.
  - Redirect to 0 → PC 0 appears next cycle and `halted`=0.
- Wrap: redirect to 1022 → PCs 1022, 1023, 0, 1 on consecutive cycles, all with `instr_valid`=1.
- Assert `Reset_n`=0 mid-run at PC 7 → `instr_valid`=0 and `fetch_count`=0 immediately.
  - Release → PC 0 appears after one FILL cycle.
  - Simultaneous redirect+halt → redirect target is presented and the unit does not halt.

Source files
------------

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC owner and fetch sequencer for a synchronous-read instruction memory
module instruction_fetch #(
    parameter int          ADDR_W   = 10,
    parameter int          DATA_W   = 32,
    parameter int unsigned RESET_PC = 0,
    parameter int          COUNT_W  = 16
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               stall,
    input  logic               halt,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [DATA_W-1:0]  imem_data,
    output logic [DATA_W-1:0]  instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic               halted,
    output logic [COUNT_W-1:0] fetch_count
);

    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  rsp_pc_q, rsp_pc_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [COUNT_W-1:0] fetch_count_q, fetch_count_d;
    logic [ADDR_W-1:0]  addr_sel;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= FILL;
            pc_q          <= RESET_ADDR;
            rsp_pc_q      <= RESET_ADDR;
            rsp_valid_q   <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            rsp_valid_q   <= rsp_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Priority: redirect > halt > stall > advance. Re-reading rsp_pc keeps imem_data stable.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        rsp_valid_d   = rsp_valid_q;
        addr_sel      = pc_q;
        fetch_count_d = fetch_count_q;

        if (rsp_valid_q && !stall) begin
            fetch_count_d = fetch_count_q + COUNT_W'(1);
        end

        if (redirect_valid) begin
            addr_sel    = redirect_addr;
            rsp_pc_d    = redirect_addr;
            pc_d        = redirect_addr + ADDR_W'(1);
            rsp_valid_d = 1'b1;
            state_d     = RUN;
        end else begin
            case (state_q)
                HALTED: begin
                    addr_sel = rsp_pc_q;
                end
                default: begin
                    if (halt) begin
                        addr_sel    = rsp_pc_q;
                        rsp_valid_d = 1'b0;
                        state_d     = HALTED;
                    end else if (stall && state_q == RUN) begin
                        addr_sel = rsp_pc_q;
                    end else begin
                        addr_sel    = pc_q;
                        rsp_pc_d    = pc_q;
                        pc_d        = pc_q + ADDR_W'(1);
                        rsp_valid_d = 1'b1;
                        state_d     = RUN;
                    end
                end
            endcase
        end
    end

    // Hold the reset address on the memory port while reset is asserted, whatever the inputs do.
    assign imem_addr   = Reset_n ? addr_sel : RESET_ADDR;
    assign instr       = imem_data;
    assign instr_pc    = rsp_pc_q;
    assign instr_valid = rsp_valid_q;
    assign halted      = (state_q == HALTED);
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed and random checks of instruction_fetch against a memory and reference model
module tb_instruction_fetch;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          stall = 1'b0;
    logic          halt = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_data = '0;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          halted;
    logic [CW-1:0] fetch_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Reference model: what decode should see, in terms of presented word and next word to fetch.
    bit            m_valid;
    bit            m_halted;
    bit            m_fill;
    int            m_shown;
    int            m_next;
    int            m_count;
    int            m_addr;

    instruction_fetch #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(0), .COUNT_W(CW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .stall(stall), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_addr(imem_addr), .imem_data(imem_data), .instr(instr),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .halted(halted),
        .fetch_count(fetch_count)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) imem_data <= mem[imem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid  = 0;
        m_halted = 0;
        m_fill   = 1;
        m_shown  = 0;
        m_next   = 0;
        m_count  = 0;
    endtask

    task automatic check_outputs();
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
        chk("halted", {31'd0, halted}, {31'd0, m_halted});
        chk("fetch_count", 32'(fetch_count), 32'(m_count % (1 << CW)));
        if (m_valid) begin
            chk("instr_pc", 32'(instr_pc), 32'(m_shown));
            chk("instr", instr, mem[m_shown]);
        end
    endtask

    task automatic step(input bit s, input bit h, input bit r, input int ra);
        @(negedge Clk);
        stall          = s;
        halt           = h;
        redirect_valid = r;
        redirect_addr  = AW'(ra);
        if (m_valid && !s) m_count++;
        if (r) begin
            m_addr = ra; m_shown = ra; m_next = (ra + 1) % (1 << AW);
            m_valid = 1; m_halted = 0; m_fill = 0;
        end else if (m_halted) begin
            m_addr = m_shown;
        end else if (h) begin
            m_addr = m_shown; m_valid = 0; m_halted = 1;
        end else if (s && !m_fill) begin
            m_addr = m_shown;
        end else begin
            m_addr = m_next; m_shown = m_next; m_next = (m_next + 1) % (1 << AW);
            m_valid = 1; m_fill = 0;
        end
        #1;
        chk("imem_addr", 32'(imem_addr), 32'(m_addr));
        @(posedge Clk);
        #1;
        check_outputs();
    endtask

    task automatic advance_to(input int pc);
        for (int i = 0; i < 2000 && !(m_valid && m_shown == pc); i++) step(0, 0, 0, 0);
        chk("advance_to_pc", 32'(instr_pc), 32'(pc));
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        mem[2] = 32'h21E21032;
        mem[5] = 32'h1C2022A2;
        mem[6] = 32'h1C432AA2;
        model_reset();

        #1;
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_count", 32'(fetch_count), 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;

        // Free run: cycles 1..6 show PCs 0..5
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        chk("pc5", 32'(instr_pc), 32'd5);
        chk("pc5_word", instr, 32'h1C2022A2);
        step(0, 0, 0, 0);
        chk("count_at_pc6", 32'(fetch_count), 32'd6);

        // Stall three cycles on PC 6
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            chk("stall_pc", 32'(instr_pc), 32'd6);
            chk("stall_word", instr, 32'h1C432AA2);
            chk("stall_count", 32'(fetch_count), 32'd6);
        end
        step(0, 0, 0, 0);
        chk("after_stall_pc", 32'(instr_pc), 32'd7);
        advance_to(10);
        step(0, 0, 0, 0);
        chk("count_11", 32'(fetch_count), 32'd11);

        // Redirect to 2 while PC 8 is presented
        redirect_valid = 0;
        step(0, 0, 1, 0);
        advance_to(8);
        step(0, 0, 1, 2);
        chk("redir_pc", 32'(instr_pc), 32'd2);
        chk("redir_word", instr, 32'h21E21032);
        step(0, 0, 0, 0);
        chk("redir_follow", 32'(instr_pc), 32'd3);

        // Halt at PC 4, ignore stall/halt for 5 cycles, exit by redirect
        advance_to(4);
        step(0, 1, 0, 0);
        chk("halt_valid", {31'd0, instr_valid}, 32'd0);
        chk("halt_flag", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 5; i++) step(bit'($urandom_range(1)), bit'($urandom_range(1)), 0, 0);
        step(0, 0, 1, 0);
        chk("unhalt_pc", 32'(instr_pc), 32'd0);
        chk("unhalt_flag", {31'd0, halted}, 32'd0);

        // Address wrap
        step(0, 0, 1, 1022);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        chk("wrap_pc", 32'(instr_pc), 32'd1);
        chk("wrap_valid", {31'd0, instr_valid}, 32'd1);

        // Asynchronous reset mid-run at PC 7
        advance_to(7);
        Reset_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, instr_valid}, 32'd0);
        chk("arst_count", 32'(fetch_count), 32'd0);
        chk("arst_imem_addr", 32'(imem_addr), 32'd0);
        model_reset();
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        step(1, 0, 0, 0);
        chk("post_rst_pc", 32'(instr_pc), 32'd0);
        chk("post_rst_valid", {31'd0, instr_valid}, 32'd1);

        // Redirect beats halt; redirect with stall does not count
        step(0, 1, 1, 500);
        chk("redir_halt_pc", 32'(instr_pc), 32'd500);
        chk("redir_halt_flag", {31'd0, halted}, 32'd0);
        step(1, 0, 1, 77);
        chk("redir_stall_pc", 32'(instr_pc), 32'd77);
        chk("redir_stall_count", 32'(fetch_count), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(3) == 0), ($urandom_range(15) == 0),
                 ($urandom_range(7) == 0), int'($urandom_range((1 << AW) - 1)));
        end

        stall = 0; halt = 0; redirect_valid = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
